// File: rtl/dmem_mmio_unit_if.sv
// Bus between the CPU MEM stage (master) and the data-memory/MMIO unit (slave).
interface dmem_mmio_unit_if;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        write_enable;
    logic [31:0] read_data;
    logic        bus_err;

    modport master (
        output address,
        output write_data,
        output write_enable,
        input  read_data,
        input  bus_err
    );

    modport slave (
        input  address,
        input  write_data,
        input  write_enable,
        output read_data,
        output bus_err
    );
endinterface

// File: rtl/dmem_mmio_unit.sv
// Data memory plus MMIO block: word RAM with combinational read, a free-running
// cycle counter, an LED register and a compare timer with a level interrupt.
module dmem_mmio_unit #(
    parameter int          RAM_AW    = 10,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter int          LED_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    dmem_mmio_unit_if.slave  bus,
    output logic [LED_W-1:0] led,
    output logic             irq
);

    localparam logic [5:0] SEL_CYCLE = 6'd0;
    localparam logic [5:0] SEL_LED   = 6'd1;
    localparam logic [5:0] SEL_TCMP  = 6'd2;
    localparam logic [5:0] SEL_TCNT  = 6'd3;
    localparam logic [5:0] SEL_TCTRL = 6'd4;

    logic [31:0]       mem [2**RAM_AW];

    logic [31:0]       cycle_reg;
    logic [LED_W-1:0]  led_reg;
    logic [31:0]       tcmp_reg;
    logic [31:0]       tcnt_reg;
    logic              en_reg;
    logic              auto_reg;
    logic              flag_reg;
    logic              ie_reg;
    logic              bus_err_reg;

    logic [RAM_AW-1:0] ram_idx;
    logic [5:0]        reg_sel;
    logic              ram_hit;
    logic              mmio_hit;
    logic              reg_defined;
    logic              mapped;
    logic              wr_led;
    logic              wr_tcmp;
    logic              wr_tcnt;
    logic              wr_tctrl;
    logic              match;
    logic [31:0]       rd_data;
    logic              unused_ok;

    // Byte-address low bits carry no information for word accesses.
    assign unused_ok   = &{1'b0, bus.address[1:0]};

    assign ram_idx     = bus.address[RAM_AW+1:2];
    assign reg_sel     = bus.address[7:2];
    assign ram_hit     = (bus.address[31:RAM_AW+2] == '0);
    assign mmio_hit    = (bus.address[31:8] == MMIO_BASE[31:8]);
    assign reg_defined = mmio_hit && (reg_sel <= SEL_TCTRL);
    assign mapped      = ram_hit || reg_defined;

    assign wr_led      = bus.write_enable && mmio_hit && (reg_sel == SEL_LED);
    assign wr_tcmp     = bus.write_enable && mmio_hit && (reg_sel == SEL_TCMP);
    assign wr_tcnt     = bus.write_enable && mmio_hit && (reg_sel == SEL_TCNT);
    assign wr_tctrl    = bus.write_enable && mmio_hit && (reg_sel == SEL_TCTRL);

    assign match       = en_reg && (tcnt_reg == tcmp_reg);

    // Word RAM: synchronous write, no reset so contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (bus.write_enable && ram_hit) begin
            mem[ram_idx] <= bus.write_data;
        end
    end

    // Combinational read mux; unmapped and undefined offsets read as zero.
    always_comb begin
        rd_data = '0;
        if (ram_hit) begin
            rd_data = mem[ram_idx];
        end else if (mmio_hit) begin
            case (reg_sel)
                SEL_CYCLE: rd_data = cycle_reg;
                SEL_LED:   rd_data = {{(32-LED_W){1'b0}}, led_reg};
                SEL_TCMP:  rd_data = tcmp_reg;
                SEL_TCNT:  rd_data = tcnt_reg;
                SEL_TCTRL: rd_data = {28'd0, ie_reg, flag_reg, auto_reg, en_reg};
                default:   rd_data = '0;
            endcase
        end
    end

    // Free-running cycle counter; software writes have no effect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_reg <= '0;
        end else begin
            cycle_reg <= cycle_reg + 32'd1;
        end
    end

    // Software-visible LED and timer configuration registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led_reg  <= '0;
            tcmp_reg <= '0;
            en_reg   <= 1'b0;
            auto_reg <= 1'b0;
            ie_reg   <= 1'b0;
        end else begin
            if (wr_led) begin
                led_reg <= bus.write_data[LED_W-1:0];
            end
            if (wr_tcmp) begin
                tcmp_reg <= bus.write_data;
            end
            if (wr_tctrl) begin
                en_reg   <= bus.write_data[0];
                auto_reg <= bus.write_data[1];
                ie_reg   <= bus.write_data[3];
            end
        end
    end

    // Timer count and flag: software write beats reload beats increment;
    // a hardware match beats a write-1-to-clear of the flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tcnt_reg <= '0;
            flag_reg <= 1'b0;
        end else begin
            if (wr_tcnt) begin
                tcnt_reg <= bus.write_data;
            end else if (match && auto_reg) begin
                tcnt_reg <= '0;
            end else if (en_reg) begin
                tcnt_reg <= tcnt_reg + 32'd1;
            end
            if (match) begin
                flag_reg <= 1'b1;
            end else if (wr_tctrl && bus.write_data[2]) begin
                flag_reg <= 1'b0;
            end
        end
    end

    // Bus error flags only stores that hit nothing; stray reads stay silent.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_err_reg <= 1'b0;
        end else begin
            bus_err_reg <= bus.write_enable && !mapped;
        end
    end

    assign bus.read_data = rd_data;
    assign bus.bus_err   = bus_err_reg;
    assign led           = led_reg;
    assign irq           = flag_reg && ie_reg;

endmodule

// File: doc/dmem_mmio_unit.md
Name: dmem_mmio_unit

Overview:
- Data-memory subsystem directly downstream of the CPU's MEM stage.
- Consumes the CPU's DMEM address, write data and write strobe; returns read data in the same cycle, as the MEM/WB register latches it at the next edge.
- Decodes the address into a word RAM region and a memory-mapped I/O region.
- The I/O region holds a free-running cycle counter, an LED register and a compare timer with interrupt flag.

Parameters:
- RAM_AW, 10: RAM word-address bits; RAM depth = 2^RAM_AW words, byte range 0 .. 4*2^RAM_AW-1.
- MMIO_BASE, 32'hFFFF_0000: MMIO region base; a region hit is address[31:8] == MMIO_BASE[31:8].
- LED_W, 16: LED register width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- address  in  32  byte address from the MEM stage
- write_data  in  32  store data
- write_enable  in  1  store strobe; high = write this cycle
- read_data  out  32  combinational read data
- led  out  LED_W  LED register contents
- irq  out  1  timer interrupt, level
- bus_err  out  1  registered one-cycle pulse on an unmapped access

Behaviour:
Address and decode
- address[1:0] is ignored; all accesses are word accesses.
- RAM hit: address < 4*2^RAM_AW. MMIO hit: region match as above. Anything else is unmapped.

RAM
- Read is combinational: read_data = mem[address[RAM_AW+1:2]].
- Write is synchronous on the rising clock edge when write_enable=1.
- A read of the location being written in the same cycle returns the old value.
- Contents are not cleared by reset.

MMIO registers (offset = address[7:0])
- 0x00 CYCLE, RO: increments every clock, wraps 0xFFFFFFFF->0. Writes are ignored.
- 0x04 LED, RW: bits [LED_W-1:0]; upper bits read 0.
- 0x08 TCMP, RW: timer compare value.
- 0x0C TCNT, RW: timer count.
- 0x10 TCTRL, RW, bit fields:
  - bit0 EN
  - bit1 AUTO (auto-reload)
  - bit2 FLAG: set by hardware, write-1-to-clear
  - bit3 IE
  - other bits read 0
- Other offsets read 0; writes to them are dropped and raise bus_err.

Timer, evaluated each edge
- match = EN & (TCNT == TCMP).
- A TCNT write takes priority over reload and increment.
- Otherwise, if match & AUTO: TCNT <= 0.
- Otherwise, if EN: TCNT <= TCNT+1, wrapping.
- FLAG: set on match; hardware set beats a W1C in the same cycle.
- A TCTRL write updates EN/AUTO/IE from write_data; FLAG follows only the set/W1C rule above.
- irq = FLAG & IE, combinational from registers.

Error handling
- Any access to an unmapped address or an undefined MMIO offset: read_data = 0, write dropped.
- bus_err pulses high for one cycle after the edge, but only when write_enable=1.
- Unmapped reads are silent, because the MEM stage presents garbage addresses for non-memory instructions.

Reset (asynchronous)
- CYCLE, LED, TCMP, TCNT, TCTRL all cleared to 0; bus_err=0; irq=0; led=0.
- An MMIO read_data reads 0 immediately.
- Reset asserted mid-count freezes all registers at 0 until deassertion.
- CYCLE first increments on the first edge after deassertion.

Latency
- Read: 0 cycles.
- Write: visible on read_data after the next edge.
- LED: output updates at the write edge.

Test Plan:
- Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0013 -> 0xDEADBEEF; same-cycle read during a write to 0x10 returns the prior value.
- Release reset and hold for 5 edges, then read 0xFFFF_0000 -> 5. Write 0x1234 to it -> next read is 6, not 0x1234.
- Write TCMP=3 and TCTRL=0xB (EN, AUTO, IE) -> TCNT sequence 0,1,2,3,0; FLAG and irq high after the match edge. Write TCTRL=0xF (W1C plus re-enable) -> FLAG clears unless a match coincides.
- TCMP=2, EN only; write TCNT=0x40 on the edge where TCNT==2 -> TCNT=0x40 and FLAG=1.
- Write 0xABCDE to 0xFFFF_0004 -> led=0xBCDE; readback = 0x0000BCDE.
- Write to 0x0001_0000 or to 0xFFFF_0020 -> bus_err pulses one cycle, RAM/regs unchanged; read of the same addresses -> 0, no bus_err.
- Assert reset while timer is running with FLAG=1 -> irq, led, TCNT drop to 0 immediately, without waiting for a clock edge.
